register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 13 +
 rtl/register_file.sv | 58 +++++
 tb/tb_register_file.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Datapath-wide constants and types shared by decode, the register file and the ALU.
package register_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : register_file_pkg

// File: rtl/regfile_read_port.sv
// Combinational 2**ADDR_W:1 read mux; zero latency, no flow control.
module regfile_read_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  assign data = regs[addr];

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 2-read / 1-write register file; writes land at the clock edge, reads are combinational
// with no write bypass, so a read of the register being written shows the old value until the edge.
module register_file #(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] srcRegA,
  input  logic [ADDR_W-1:0] srcRegB,
  input  logic [ADDR_W-1:0] destReg,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] outBusA,
  output logic [DATA_W-1:0] outBusB
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    logic              we;
    logic [DATA_W-1:0] q;

    assign we = regWrite && (destReg == ADDR_W'(i));

    // Reset wins over a write on the same edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        q <= '0;
      end else if (we) begin
        q <= writeData;
      end
    end

    assign regs[i] = q;
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_a (
    .regs (regs),
    .addr (srcRegA),
    .data (outBusA)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_b (
    .regs (regs),
    .addr (srcRegB),
    .data (outBusB)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed stimulus pushes expected read values into a scoreboard; a monitor on the falling edge pops and compares.
module tb_register_file;
  import register_file_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      regWrite;
  reg_addr_t srcRegA, srcRegB, destReg;
  word_t     writeData;
  word_t     outBusA, outBusB;

  logic  chk_vld = 1'b0;
  string name_q[$];
  word_t exp_a_q[$];
  word_t exp_b_q[$];
  int    checks   = 0;
  int    failures = 0;

  register_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .srcRegA   (srcRegA),
    .srcRegB   (srcRegB),
    .destReg   (destReg),
    .writeData (writeData),
    .outBusA   (outBusA),
    .outBusB   (outBusB)
  );

  always #5 clk = ~clk;

  // Monitor: compares whenever the stimulus flags a read as ready to sample.
  always @(negedge clk) begin
    if (chk_vld) begin
      checks++;
      if (name_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty actual=sample_requested required=queued_expectation");
      end else begin
        string n;
        word_t ea, eb;
        n  = name_q.pop_front();
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        if (outBusA !== ea || outBusB !== eb) begin
          failures++;
          $display("FAIL %s actual A=%h B=%h required A=%h B=%h", n, outBusA, outBusB, ea, eb);
        end
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present read addresses, queue the expectation, let the monitor sample, then step one edge.
  task automatic expect_read(input string n, input reg_addr_t a, input reg_addr_t b,
                             input word_t ea, input word_t eb);
    srcRegA = a;
    srcRegB = b;
    name_q.push_back(n);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    chk_vld = 1'b1;
    @(negedge clk);
    #1;
    chk_vld = 1'b0;
    cycle();
  endtask

  task automatic write_reg(input reg_addr_t d, input word_t v);
    regWrite  = 1'b1;
    destReg   = d;
    writeData = v;
    cycle();
    regWrite  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    regWrite  = 1'b0;
    srcRegA   = '0;
    srcRegB   = '0;
    destReg   = '0;
    writeData = '0;
    cycle();
    reset = 1'b0;

    // Reset clear: every address reads zero on both ports.
    for (int i = 0; i < NUM_REGS; i++)
      expect_read("reset_clear", reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i), 16'h0000, 16'h0000);

    // Sequential writes on consecutive edges.
    regWrite = 1'b1;
    destReg = 4'd2; writeData = 16'd2; cycle();
    destReg = 4'd4; writeData = 16'd4; cycle();
    destReg = 4'd6; writeData = 16'd6; cycle();
    destReg = 4'd8; writeData = 16'd8; cycle();
    regWrite = 1'b0;
    expect_read("seq_1_2", 4'd1, 4'd2, 16'h0000, 16'h0002);
    expect_read("seq_3_4", 4'd3, 4'd4, 16'h0000, 16'h0004);
    expect_read("seq_5_6", 4'd5, 4'd6, 16'h0000, 16'h0006);
    expect_read("seq_7_8", 4'd7, 4'd8, 16'h0000, 16'h0008);

    // Write disabled: destReg/writeData toggling must not reach r5.
    regWrite  = 1'b0;
    destReg   = 4'd5;
    writeData = 16'hFFFF;
    repeat (4) cycle();
    expect_read("write_disable_r5", 4'd5, 4'd2, 16'h0000, 16'h0002);

    // Same register on both ports, no bypass before the write edge.
    regWrite  = 1'b1;
    destReg   = 4'd9;
    writeData = 16'hA5A5;
    expect_read("no_bypass_before", 4'd9, 4'd9, 16'h0000, 16'h0000);
    regWrite  = 1'b0;
    expect_read("dual_read_after", 4'd9, 4'd9, 16'hA5A5, 16'hA5A5);
    expect_read("neighbours_intact", 4'd8, 4'd10, 16'h0008, 16'h0000);

    // Reset priority over a same-edge write.
    reset     = 1'b1;
    regWrite  = 1'b1;
    destReg   = 4'd3;
    writeData = 16'h1234;
    cycle();
    reset    = 1'b0;
    regWrite = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      expect_read("reset_priority", reg_addr_t'(i), reg_addr_t'((i + 3) % NUM_REGS), 16'h0000, 16'h0000);

    // Extremes: r0 is ordinary storage, r15 is the top address.
    write_reg(4'd0, 16'hFFFF);
    write_reg(4'd15, 16'h8001);
    expect_read("extremes", 4'd0, 4'd15, 16'hFFFF, 16'h8001);
    expect_read("extremes_swapped", 4'd15, 4'd0, 16'h8001, 16'hFFFF);
    expect_read("extremes_neighbours", 4'd1, 4'd14, 16'h0000, 16'h0000);

    // Overwrite an existing value.
    write_reg(4'd0, 16'h0001);
    expect_read("overwrite_r0", 4'd0, 4'd15, 16'h0001, 16'h8001);

    repeat (2) cycle();
    if (name_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", name_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file
